// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG block constants, run decoder state and symbol codes
package jpeg_pkg;

   localparam int NCOEF = 64;
   localparam int CW    = 11;

   typedef enum logic [2:0] {
      S_DC,
      S_AC,
      S_RUN,
      S_COEF,
      S_EOB
   } rdec_state_t;

   // {run, size} codes of the two special AC symbols
   localparam logic [7:0] SYM_EOB = 8'h00;
   localparam logic [7:0] SYM_ZRL = 8'hF0;

   typedef logic signed [CW-1:0] coef_t;

endpackage

// File: rtl/ones_decoder.sv
// rtl/ones_decoder.sv - combinational ones-complement amplitude decode (inverse of the encoder-side ones encoder)
module ones_decoder #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0]        val,
   input  logic [3:0]              size,
   output logic signed [WIDTH:0]   coef
);

   logic [WIDTH:0] mask;
   logic [WIDTH:0] bits;
   logic [WIDTH:0] top;

   // Top significant bit set means positive; otherwise subtract 2^size-1 (size 0 yields 0)
   always_comb begin
      mask = ~({(WIDTH+1){1'b1}} << size);
      bits = {1'b0, val} & mask;
      top  = mask ^ (mask >> 1);
      coef = (|(bits & top)) ? $signed(bits) : $signed(bits - mask);
   end

endmodule

// File: rtl/run_decoder.sv
// rtl/run_decoder.sv - JPEG run/size/amplitude symbol expander to zigzag coefficients; optional RUN_DECODER_ERR_EN overflow flag
module run_decoder import jpeg_pkg::*; #(
   parameter int NCOEF = jpeg_pkg::NCOEF,
   parameter int CW    = jpeg_pkg::CW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena_in,
   output logic                 rdy_out,
   input  logic signed [CW-1:0] in_dc,
   input  logic [CW-2:0]        in_val,
   input  logic [3:0]           run,
   input  logic [3:0]           size,
   input  logic                 rdy_in,
   output logic                 ena_out,
   output logic signed [CW-1:0] out,
   output logic [5:0]           idx_out,
   output logic                 done,
   output logic                 err
);

   localparam logic [5:0] LAST = 6'(NCOEF - 1);

   rdec_state_t          state, state_nx;
   logic                 live;
   logic [5:0]           idx, idx_nx;
   logic [4:0]           zcnt, zcnt_nx;
   logic                 pend, pend_nx;
   logic signed [CW-1:0] hold, hold_nx;
   logic signed [CW-1:0] amp;

   logic                 accept;
   logic                 xfer;
   logic                 blk_end;
   logic [7:0]           sym;
   logic [4:0]           zrl_len;

   ones_decoder #(.WIDTH(CW-1)) u_amp (
      .val  (in_val),
      .size (size),
      .coef (amp)
   );

   assign accept  = ena_in && rdy_out;
   assign xfer    = ena_out && rdy_in;
   assign blk_end = xfer && (idx == LAST);
   assign sym     = {run, size};
   // A ZRL stands for 16 zeros; any other size-0 run is taken literally
   assign zrl_len = (sym == SYM_ZRL) ? 5'd16 : {1'b0, run};

   // State register; live holds outputs quiet until the first edge after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_DC;
         live  <= 1'b0;
         idx   <= '0;
         zcnt  <= '0;
         pend  <= 1'b0;
         hold  <= '0;
      end else begin
         state <= state_nx;
         live  <= 1'b1;
         idx   <= idx_nx;
         zcnt  <= zcnt_nx;
         pend  <= pend_nx;
         hold  <= hold_nx;
      end
   end

   // Next-state and datapath update; a transfer at the last index always restarts the block
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      zcnt_nx  = zcnt;
      pend_nx  = pend;
      hold_nx  = hold;
      case (state)
         S_DC: begin
            if (accept) begin
               hold_nx  = in_dc;
               state_nx = S_COEF;
            end
         end
         S_AC: begin
            if (accept) begin
               if (sym == SYM_EOB) begin
                  state_nx = S_EOB;
               end else if (size == 4'd0) begin
                  zcnt_nx  = zrl_len;
                  pend_nx  = 1'b0;
                  state_nx = S_RUN;
               end else begin
                  hold_nx  = amp;
                  pend_nx  = 1'b1;
                  zcnt_nx  = {1'b0, run};
                  state_nx = (run != 4'd0) ? S_RUN : S_COEF;
               end
            end
         end
         S_RUN: begin
            if (xfer) begin
               zcnt_nx = zcnt - 5'd1;
               if (zcnt == 5'd1) state_nx = pend ? S_COEF : S_AC;
            end
         end
         S_COEF: begin
            if (xfer) begin
               pend_nx  = 1'b0;
               state_nx = S_AC;
            end
         end
         default: ;
      endcase
      if (xfer) idx_nx = idx + 6'd1;
      if (blk_end) begin
         idx_nx   = '0;
         zcnt_nx  = '0;
         pend_nx  = 1'b0;
         state_nx = S_DC;
      end
   end

   // Outputs decoded from registered state
   always_comb begin
      rdy_out = live && ((state == S_DC) || (state == S_AC));
      ena_out = live && ((state == S_RUN) || (state == S_COEF) || (state == S_EOB));
      out     = (state == S_COEF) ? hold : '0;
      idx_out = idx;
      done    = ena_out && rdy_in && (idx == LAST);
   end

`ifdef RUN_DECODER_ERR_EN
   logic [6:0] need;
   logic [6:0] room;
   logic       err_q;

   assign need = (size == 4'd0) ? {2'b00, zrl_len} : ({3'b000, run} + 7'd1);
   assign room = 7'(NCOEF) - {1'b0, idx};

   // Sticky flag: a symbol asking for more positions than the block has left
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          err_q <= 1'b0;
      else if (accept && (state == S_AC) && need > room) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_run_decoder.sv
// tb/tb_run_decoder.sv - scoreboard bench for run_decoder
module tb_run_decoder;

   localparam int NC = 64;
   localparam int CW = 11;
`ifdef RUN_DECODER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 ena_in = 1'b0;
   logic                 rdy_out;
   logic signed [CW-1:0] in_dc = '0;
   logic [CW-2:0]        in_val = '0;
   logic [3:0]           run = '0;
   logic [3:0]           size = '0;
   logic                 rdy_in = 1'b1;
   logic                 ena_out;
   logic signed [CW-1:0] out;
   logic [5:0]           idx_out;
   logic                 done;
   logic                 err;

   run_decoder dut (
      .clk(clk), .rst(rst), .ena_in(ena_in), .rdy_out(rdy_out),
      .in_dc(in_dc), .in_val(in_val), .run(run), .size(size),
      .rdy_in(rdy_in), .ena_out(ena_out), .out(out), .idx_out(idx_out),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; int val; bit dn;} exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;
   int m_idx = 0;
   bit m_first = 1'b1;
   bit m_err = 1'b0;
   bit rand_rdy = 1'b0;
   bit after_done = 1'b0;

   task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int amp(int s, int v);
      int mask = (1 << s) - 1;
      int b = v & mask;
      if (s == 0) return 0;
      if (((b >> (s - 1)) & 1) == 1) return b;
      return b - mask;
   endfunction

   task automatic emit(int v);
      exp_t e;
      e.idx = m_idx;
      e.val = v;
      e.dn  = (m_idx == NC - 1);
      sb.push_back(e);
      if (m_idx == NC - 1) begin
         m_idx = 0;
         m_first = 1'b1;
      end else begin
         m_idx++;
      end
   endtask

   task automatic model_sym(int dc, int r, int s, int v);
      int n;
      if (m_first) begin
         m_first = 1'b0;
         emit(dc);
         return;
      end
      if (s == 0 && r == 0) begin
         emit(0);
         while (!m_first) emit(0);
         return;
      end
      n = (s == 0) ? ((r == 15) ? 16 : r) : r;
      if (n + ((s != 0) ? 1 : 0) > NC - m_idx) m_err = 1'b1;
      for (int i = 0; i < n && !m_first; i++) emit(0);
      if (s != 0 && !m_first) emit(amp(s, v));
   endtask

   task automatic send(int dc, int r, int s, int v);
      int cnt = 0;
      model_sym(dc, r, s, v);
      @(negedge clk);
      in_dc  = dc[CW-1:0];
      run    = r[3:0];
      size   = s[3:0];
      in_val = v[CW-2:0];
      ena_in = 1'b1;
      while (!rdy_out && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      if (!rdy_out) begin
         chk("accept_timeout", 32'(rdy_out), 1);
         ena_in = 1'b0;
         return;
      end
      @(posedge clk);
      #1 ena_in = 1'b0;
   endtask

   task automatic drain();
      int cnt = 0;
      while (sb.size() != 0 && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      ena_in = 1'b0;
      sb.delete();
      m_idx = 0;
      m_first = 1'b1;
      m_err = 1'b0;
      #1;
      chk("rst_rdy_out", 32'(rdy_out), 0);
      chk("rst_ena_out", 32'(ena_out), 0);
      chk("rst_idx", 32'(idx_out), 0);
      chk("rst_out", $signed(out), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("rdy_before_edge", 32'(rdy_out), 0);
      @(posedge clk);
      #1 chk("rdy_after_edge", 32'(rdy_out), 1);
   endtask

   // Downstream ready changes just after the active edge
   always @(posedge clk) begin
      #1 rdy_in = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: pop the scoreboard on every transfer
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         after_done = 1'b0;
      end else begin
         if (after_done) begin
            chk("rdy_after_done", 32'(rdy_out), 1);
            after_done = 1'b0;
         end
         if (ena_out && rdy_in) begin
            if (sb.size() == 0) begin
               chk("unexpected_xfer", 32'(idx_out), -1);
            end else begin
               e = sb.pop_front();
               chk("idx", 32'(idx_out), e.idx);
               chk("out", $signed(out), e.val);
               chk("done", 32'(done), 32'(e.dn));
               if (e.dn) after_done = 1'b1;
            end
         end
      end
   end

   initial begin
      int cnt;
      @(negedge clk);
      do_reset();

      // DC 12 then EOB
      send(12, 0, 0, 0);
      send(0, 0, 0, 0);
      drain();
      chk("err_t1", 32'(err), 0);

      // DC -3, run 2 size 3 val 010 (-5), EOB
      send(-3, 0, 0, 0);
      send(0, 2, 3, 3'b010);
      send(0, 0, 0, 0);
      drain();

      // DC 0, ZRL, run 3 size 1 val 1, EOB
      send(0, 0, 0, 0);
      send(0, 15, 0, 0);
      send(0, 3, 1, 1);
      send(0, 0, 0, 0);
      drain();
      chk("err_t3", 32'(err), 0);

      // Full block of nonzero coefficients, no EOB; next symbol is DC
      send(1, 0, 0, 0);
      for (int i = 0; i < NC - 1; i++) send(0, 0, 1, 1);
      send(9, 0, 1, 1);
      send(0, 5, 3, 3'b101);
      send(0, 0, 0, 0);
      drain();
      chk("err_t4", 32'(err), 0);

      // Overflow: third ZRL runs past the block end
      send(5, 0, 0, 0);
      send(0, 15, 2, 2'b11);
      for (int i = 0; i < 3; i++) send(0, 15, 0, 0);
      send(0, 0, 1, 0);
      drain();
      chk("err_ovf", 32'(err), 32'(ERR_EN && m_err));
      @(negedge clk);
      do_reset();

      // Stalls, then asynchronous reset mid-block
      rand_rdy = 1'b1;
      send(4, 0, 0, 0);
      send(0, 2, 3, 3'b101);
      send(0, 0, 0, 0);
      cnt = 0;
      while (!(ena_out && idx_out == 6'd30) && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      chk("reach_idx30", 32'(idx_out), 30);
      do_reset();
      rand_rdy = 1'b0;
      send(-7, 1, 1, 1);
      send(0, 0, 0, 0);
      drain();
      chk("err_final", 32'(err), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
